// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: FSM state encoding and frame geometry.
// Imported by the loader top and its word assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: shifts stream bytes MSB-first into a 32-bit word.
// Ports: clr/shift_en control, byte_in data, word_next, last (4th byte due), full.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last,
  output logic        full
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        full_q, full_d;

  assign last = (idx_q == 2'(WORD_BYTES - 1));
  assign full = full_q;

  always_comb begin
    word_next = {word_q[23:0], byte_in};
    word_d    = word_q;
    idx_d     = idx_q;
    full_d    = full_q;
    if (clr) begin
      word_d = '0;
      idx_d  = '0;
      full_d = 1'b0;
    end else if (shift_en) begin
      word_d = word_next;
      idx_d  = idx_q + 2'd1;
      full_d = last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream -> consecutive big-endian imem words,
// holding the core while loading. Optional checksum: IMEM_LOADER_CSUM_EN.
// Ports: start, rx_data/rx_valid/rx_ready stream, im_we/im_addr/im_wdata
// write port, cpu_hold, busy, done (pulse), error (sticky).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e S_TAIL = S_CSUM;
  logic [CSUM_W-1:0] sum_q, sum_d, sum_nx;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rx_ready_q, rx_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        xfer;
  logic [15:0] len_cat;
  logic        asm_clr, asm_shift, asm_last, asm_full;
  logic [31:0] asm_next;

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (asm_clr),
    .shift_en  (asm_shift),
    .byte_in   (rx_data),
    .word_next (asm_next),
    .last      (asm_last),
    .full      (asm_full)
  );

  assign xfer    = rx_valid && rx_ready_q;
  assign len_cat = {len_q[15:8], rx_data};

`ifdef IMEM_LOADER_CSUM_EN
  assign sum_nx = sum_q + rx_data;

  always_comb begin
    sum_d = sum_q;
    if (state_q == S_IDLE || state_q == S_ERROR) begin
      if (start) sum_d = '0;
    end else if (xfer && state_q != S_CSUM) begin
      sum_d = sum_nx;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    widx_d     = widx_q;
    addr_d     = addr_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    asm_clr    = 1'b0;
    asm_shift  = 1'b0;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          asm_clr = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d   = {rx_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d  = len_cat;
          widx_d = '0;
          addr_d = BASE;
          if (int'({16'h0, len_cat}) > MAX_WORDS) state_d = S_ERROR;
          else if (len_cat == 16'h0)             state_d = S_TAIL;
          else                                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_shift = 1'b1;
          // Word address/data are latched here so they are registered
          // and stable for the whole WRITE cycle.
          if (asm_last) begin
            state_d    = S_WRITE;
            im_addr_d  = addr_q;
            im_wdata_d = asm_next;
          end
        end
      end
      S_WRITE: begin
        asm_clr = 1'b1;
        if (asm_full) begin
          widx_d = widx_q + 16'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
        state_d = (widx_d == len_q) ? S_TAIL : S_DATA;
      end
      S_CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        if (xfer) state_d = (sum_nx == '0) ? S_DONE : S_ERROR;
`else
        state_d = S_ERROR;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with it.
  always_comb begin
    rx_ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM};
    im_we_d    = (state_d == S_WRITE);
    hold_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      widx_q     <= '0;
      addr_q     <= BASE;
      rx_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      addr_q     <= addr_d;
      rx_ready_q <= rx_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rx_ready = rx_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = hold_q;
  assign busy     = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
